// File: rtl/midi_tx_encoder_if.sv
// Message handshake bundle between a MIDI message source and midi_tx_encoder.
interface midi_tx_encoder_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [3:0] msg_type;
  logic [3:0] msg_ch;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       msg_err;

  modport master (
    output msg_valid, msg_type, msg_ch, msg_data1, msg_data2,
    input  msg_ready, msg_err
  );

  modport slave (
    input  msg_valid, msg_type, msg_ch, msg_data1, msg_data2,
    output msg_ready, msg_err
  );
endinterface

// File: rtl/midi_tx_encoder.sv
// MIDI channel-message encoder and 8N1 serializer (LSB first, idle high).
// Optional MIDI_RUNNING_STATUS_EN omits a status byte equal to the last one sent.
module midi_tx_encoder #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 31_250
) (
  input  logic              sysclk,
  input  logic              reset,
  midi_tx_encoder_if.slave  bus,
  output logic              busy,
  output logic              midi_txd
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       status_q, status_d;
  logic [6:0]       d1_q, d1_d;
  logic [6:0]       d2_q, d2_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]       ls_q, ls_d;
  logic             ls_valid_q, ls_valid_d;
`endif

  logic       len3, len2, rs_hit, baud_end;
  logic [7:0] tx_byte;

  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state, capture and line-level logic; txd is computed from next state so it is registered.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    last_d   = last_q;
    status_d = status_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    err_d    = 1'b0;
    len3     = 1'b0;
    len2     = 1'b0;
    rs_hit   = 1'b0;
    tx_byte  = status_q;
    txd_d    = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
    ls_d       = ls_q;
    ls_valid_d = ls_valid_q;
    rs_hit     = ls_valid_q && (ls_q == {bus.msg_type, bus.msg_ch});
`endif

    case (bus.msg_type)
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len3 = 1'b1;
      4'hC, 4'hD:                   len2 = 1'b1;
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.msg_valid && ready_q) begin
          if (len3 || len2) begin
            status_d = {bus.msg_type, bus.msg_ch};
            d1_d     = bus.msg_data1;
            d2_d     = bus.msg_data2;
            last_d   = len3 ? 2'd2 : 2'd1;
            idx_d    = rs_hit ? 2'd1 : 2'd0;
            baud_d   = '0;
            bit_d    = 3'd0;
            ready_d  = 1'b0;
            busy_d   = 1'b1;
            state_d  = START;
`ifdef MIDI_RUNNING_STATUS_EN
            ls_d       = {bus.msg_type, bus.msg_ch};
            ls_valid_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = 3'd0;
          if (idx_q == last_q) begin
            idx_d   = 2'd0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (idx_d)
      2'd0:    tx_byte = status_d;
      2'd1:    tx_byte = {1'b0, d1_d};
      default: tx_byte = {1'b0, d2_d};
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = tx_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  // State register; synchronous reset aborts any frame in progress.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      idx_q    <= 2'd0;
      last_q   <= 2'd0;
      status_q <= 8'h00;
      d1_q     <= 7'h00;
      d2_q     <= 7'h00;
      txd_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      ls_q       <= 8'h00;
      ls_valid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef MIDI_RUNNING_STATUS_EN
      ls_q       <= ls_d;
      ls_valid_q <= ls_valid_d;
`endif
    end
  end

  assign bus.msg_ready = ready_q;
  assign bus.msg_err   = err_q;
  assign busy          = busy_q;
  assign midi_txd      = txd_q;

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Bench for midi_tx_encoder: message table plus hand sequences, line bytes checked by a UART monitor.
module tb_midi_tx_encoder;

  localparam int unsigned CLK_HZ = 500_000;
  localparam int unsigned BAUD   = 31_250;
  localparam int          DIV    = CLK_HZ / BAUD;
  localparam int          BUDGET = 40 * DIV;

  typedef struct {
    logic [3:0] typ;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
    bit         err;
    int         nbytes;
  } vec_t;

  logic sysclk;
  logic reset;
  logic busy;
  logic midi_txd;

  midi_tx_encoder_if bus ();

  midi_tx_encoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .midi_txd(midi_txd)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ls_model = 8'h00;
  bit         ls_valid_model = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: decides the bytes a message should produce and queues them.
  task automatic model_push(input vec_t v, output int nb);
    logic [7:0] st;
    bit skip;
    st   = {v.typ, v.ch};
    skip = 1'b0;
    nb   = 0;
    if (!v.err) begin
`ifdef MIDI_RUNNING_STATUS_EN
      skip           = ls_valid_model && (ls_model == st);
      ls_model       = st;
      ls_valid_model = 1'b1;
`endif
      if (!skip) exp_q.push_back(st);
      exp_q.push_back({1'b0, v.d1});
      if (v.nbytes == 3) exp_q.push_back({1'b0, v.d2});
      nb = v.nbytes - (skip ? 1 : 0);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.msg_type  = v.typ;
    bus.msg_ch    = v.ch;
    bus.msg_data1 = v.d1;
    bus.msg_data2 = v.d2;
  endtask

  task automatic scramble();
    bus.msg_type  = 4'($urandom);
    bus.msg_ch    = 4'($urandom);
    bus.msg_data1 = 7'($urandom);
    bus.msg_data2 = 7'($urandom);
  endtask

  // Presents one message, checks acceptance, latency, busy window; returns at the first idle negedge.
  task automatic run_msg(input vec_t v, input bit keep_valid, input vec_t nxt, output int waits);
    int nb;
    int n;
    drive(v);
    bus.msg_valid = 1'b1;
    waits = 0;
    while (!bus.msg_ready && waits < BUDGET) begin
      @(negedge sysclk);
      waits++;
    end
    if (!bus.msg_ready) begin
      chk("accept_timeout", 32'(bus.msg_ready), 1);
      bus.msg_valid = 1'b0;
      return;
    end
    model_push(v, nb);
    @(negedge sysclk);
    if (keep_valid) drive(nxt);
    else begin
      bus.msg_valid = 1'b0;
      scramble();
    end
    chk("msg_err_after_accept", 32'(bus.msg_err), 32'(v.err));
    chk("ready_after_accept", 32'(bus.msg_ready), 32'(v.err));
    chk("busy_after_accept", 32'(busy), 32'(!v.err));
    chk("start_bit_latency", 32'(midi_txd), 32'(v.err));
    if (v.err) begin
      @(negedge sysclk);
      chk("err_pulse_width", 32'(bus.msg_err), 0);
      chk("err_line_idle", 32'(midi_txd), 1);
      chk("err_ready_held", 32'(bus.msg_ready), 1);
    end else begin
      n = 0;
      while (busy && n < BUDGET) begin
        n++;
        @(negedge sysclk);
      end
      chk("busy_cycles", 32'(n), 32'(nb * 10 * DIV));
      chk("ready_after_frame", 32'(bus.msg_ready), 1);
    end
  endtask

  // UART line monitor: samples mid-bit, checks start/stop, compares bytes against the queue.
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge sysclk) begin
    int k;
    logic [7:0] e;
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (midi_txd == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % DIV == DIV / 2) begin
        k = mon_cnt / DIV;
        if (k == 0) chk("start_bit_level", 32'(midi_txd), 0);
        else if (k <= 8) mon_byte[3'(k - 1)] = midi_txd;
        else begin
          chk("stop_bit_level", 32'(midi_txd), 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL line_byte: actual %02h required none at %0t", mon_byte, $time);
          end else begin
            e = exp_q.pop_front();
            chk("line_byte", 32'(mon_byte), 32'(e));
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  vec_t tbl[10];
  vec_t v1, v2, vn, vr;
  int   w;

  initial begin
    tbl[0] = '{4'h9, 4'h0, 7'h3C, 7'h64, 1'b0, 3};
    tbl[1] = '{4'hC, 4'h5, 7'h07, 7'h00, 1'b0, 2};
    tbl[2] = '{4'hF, 4'h0, 7'h11, 7'h22, 1'b1, 0};
    tbl[3] = '{4'h3, 4'h0, 7'h33, 7'h44, 1'b1, 0};
    tbl[4] = '{4'hE, 4'h1, 7'h00, 7'h40, 1'b0, 3};
    tbl[5] = '{4'hD, 4'h3, 7'h55, 7'h00, 1'b0, 2};
    tbl[6] = '{4'hA, 4'hF, 7'h7F, 7'h7F, 1'b0, 3};
    tbl[7] = '{4'h9, 4'h1, 7'h3C, 7'h40, 1'b0, 3};
    tbl[8] = '{4'h9, 4'h1, 7'h3E, 7'h40, 1'b0, 3};
    tbl[9] = '{4'h9, 4'h2, 7'h3C, 7'h40, 1'b0, 3};
    vn     = '{4'h0, 4'h0, 7'h00, 7'h00, 1'b1, 0};

    reset         = 1'b1;
    bus.msg_valid = 1'b0;
    drive(vn);
    repeat (3) @(negedge sysclk);
    chk("reset_txd", 32'(midi_txd), 1);
    chk("reset_ready", 32'(bus.msg_ready), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_err", 32'(bus.msg_err), 0);
    reset = 1'b0;
    @(negedge sysclk);
    chk("idle_txd", 32'(midi_txd), 1);

    for (int i = 0; i < 10; i++) begin
      run_msg(tbl[i], 1'b0, vn, w);
      repeat (3) @(negedge sysclk);
    end

    // Back-to-back with msg_valid held: second accepted on the first idle cycle.
    v1 = '{4'h8, 4'h2, 7'h40, 7'h00, 1'b0, 3};
    v2 = '{4'hB, 4'h2, 7'h07, 7'h7F, 1'b0, 3};
    run_msg(v1, 1'b1, v2, w);
    chk("b2b_gap_txd", 32'(midi_txd), 1);
    chk("b2b_gap_busy", 32'(busy), 0);
    run_msg(v2, 1'b0, vn, w);
    chk("b2b_accept_wait", 32'(w), 0);
    repeat (3) @(negedge sysclk);

    // Reset in the middle of a note-on frame, then a clean message.
    vr = '{4'h9, 4'h0, 7'h3C, 7'h64, 1'b0, 3};
    drive(vr);
    bus.msg_valid = 1'b1;
    model_push(vr, w);
    @(negedge sysclk);
    bus.msg_valid = 1'b0;
    scramble();
    repeat (100) @(negedge sysclk);
    chk("midframe_busy", 32'(busy), 1);
    reset = 1'b1;
    exp_q.delete();
    ls_valid_model = 1'b0;
    @(negedge sysclk);
    chk("abort_txd", 32'(midi_txd), 1);
    chk("abort_ready", 32'(bus.msg_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    chk("post_reset_txd", 32'(midi_txd), 1);
    run_msg(vr, 1'b0, vn, w);
    repeat (DIV) @(negedge sysclk);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_tx_encoder.md
Name: midi_tx_encoder

Overview:
Encodes one MIDI channel message (type nibble, channel, up to two data bytes) into status and data bytes, then serializes them on a MIDI UART line: 31250 baud, 8N1, LSB first, idle high. It is the transmit-side counterpart of the synth controller's MIDI status decoding, and drives MIDI-out/thru from the synth controller.
- Single-message handshake.
- Fixed per-type byte count.
- Zero inter-byte gap.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 31250, line bit rate; bit period DIV = CLK_HZ/BAUD (integer division; 1600 at defaults)

Ports:
sysclk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
msg_valid  input  1  message presented on msg_* inputs
msg_ready  output  1  block can accept a message this cycle
msg_type  input  4  status high nibble (8..E accepted)
msg_ch  input  4  MIDI channel, status low nibble
msg_data1  input  7  first data byte (key/controller/program/pitch LSB)
msg_data2  input  7  second data byte (velocity/value/pitch MSB)
msg_err  output  1  one-cycle pulse: message with unsupported type was consumed and dropped
busy  output  1  high while a message is being serialized
midi_txd  output  1  serial MIDI out, idle 1

Behaviour:
- Clock and reset: one clock (sysclk); reset is synchronous and active-high.
- Reset values:
  - midi_txd=1, msg_ready=1, busy=0, msg_err=0.
  - FSM in IDLE; baud counter, bit counter and byte index all 0.
- Handshake:
  - A message is accepted on a cycle with msg_valid && msg_ready.
  - msg_ready=1 only in IDLE and is 0 the cycle after acceptance.
  - All msg_* inputs are captured into internal registers at acceptance; later changes to the inputs are ignored.
- Type decode:
  - Types 8, 9, A, B, E → 3 bytes.
  - Types C, D → 2 bytes.
  - Types 0..7 and F → msg_err=1 for exactly the cycle after acceptance; nothing transmitted; FSM stays IDLE; msg_ready stays 1.
- Bytes sent, in order:
  - status = {msg_type, msg_ch}
  - {1'b0, msg_data1}
  - {1'b0, msg_data2} (3-byte types only)
- FSM: IDLE → START → DATA → STOP → (next byte: START | last byte: IDLE).
  - START: midi_txd=0 for DIV cycles. It begins the cycle after acceptance, so latency from acceptance to the start-bit edge is 1 cycle.
  - DATA: 8 bits, LSB first, each held DIV cycles; bit counter 0..7.
  - STOP: midi_txd=1 for DIV cycles.
  - After STOP: START of the next byte on the following cycle, or IDLE after the last byte.
- Frame timing:
  - Each byte occupies exactly 10*DIV cycles.
  - A 3-byte message occupies 30*DIV cycles; a 2-byte message occupies 20*DIV cycles.
- Baud counter:
  - Counts 0..DIV-1 and wraps to 0 at DIV-1, which advances the bit.
  - Width is clog2(DIV).
- busy:
  - 1 from the cycle after acceptance through the last stop-bit cycle.
  - Returns to 0 the same cycle msg_ready returns to 1.
- Back-to-back: if msg_valid is held, the next message is accepted on the first IDLE cycle. The gap between the previous stop bit and the next start bit is therefore 1 cycle.
- Reset mid-frame:
  - Abort immediately; midi_txd=1 the next cycle.
  - All state is cleared, including running-status memory.
  - The partial byte is not completed.
- msg_err and acceptance are mutually exclusive with transmission: no message is ever accepted while busy.

Optional Feature:
MIDI_RUNNING_STATUS_EN
- With the macro:
  - A register last_status (plus a valid bit) holds the most recent transmitted status byte. It is cleared by reset.
  - An accepted message whose status equals the valid last_status skips the status byte, transmitting only its data bytes: 2 bytes for 3-byte types, 1 byte for 2-byte types.
  - Rejected messages (msg_err) leave last_status unchanged.
- Without the macro: last_status logic is absent and every message transmits its status byte.

Test Plan:
1. Note-on: type 9, ch 0, data1=0x3C, data2=0x64 → line bytes 0x90, 0x3C, 0x64.
   - Start bit begins 1 cycle after acceptance.
   - busy high for 48000 cycles at defaults, then msg_ready=1.
2. Program change: type C, ch 5, data1=0x07 → bytes 0xC5, 0x07 only; 32000-cycle busy window.
3. Invalid type F, then type 3 → msg_err pulses 1 cycle each; midi_txd stays 1; msg_ready never drops.
4. msg_valid held with two messages (8/ch2/0x40/0x00, then B/ch2/0x07/0x7F):
   - second accepted on the first IDLE cycle;
   - bytes 0x82,0x40,0x00,0xB2,0x07,0x7F;
   - 1-cycle idle gap between the two messages.
5. Reset asserted 5000 cycles into a note-on → midi_txd=1, msg_ready=1, busy=0 next cycle; a following message transmits cleanly from its start bit.
6. With MIDI_RUNNING_STATUS_EN: two note-ons on ch 1 (0x3C/0x40 then 0x3E/0x40):
   - line bytes 0x91,0x3C,0x40,0x3E,0x40;
   - a subsequent ch 2 note-on re-sends status 0x92.
